// File: rtl/mem_line_arb.sv
// mem_line_arb: two-requester round-robin arbiter that moves whole cache-style
// lines (L = 2**LINE_ADDR_LEN words of 32 bits) to and from a single-port word
// memory with a one-cycle registered read path.
//
// Handshake: rqN_req is a level request sampled only while the block is idle.
// The granted requester's we/addr/wdata are latched at the grant edge. rqN_done
// is a one-cycle acknowledge, and the requester must drop rqN_req by the edge
// that ends its done cycle. A request still high after done is a new request.
module mem_line_arb #(
    parameter int ADDR_LEN      = 11,
    parameter int LINE_ADDR_LEN = 3,
    localparam int L            = 1 << LINE_ADDR_LEN,
    localparam int LW           = ADDR_LEN - LINE_ADDR_LEN
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                rq0_req,
    input  logic                rq0_we,
    input  logic [LW-1:0]       rq0_addr,
    input  logic [32*L-1:0]     rq0_wdata,
    output logic [32*L-1:0]     rq0_rdata,
    output logic                rq0_done,

    input  logic                rq1_req,
    input  logic                rq1_we,
    input  logic [LW-1:0]       rq1_addr,
    input  logic [32*L-1:0]     rq1_wdata,
    output logic [32*L-1:0]     rq1_rdata,
    output logic                rq1_done,

    output logic [ADDR_LEN-1:0] mem_addr,
    output logic                mem_wr_req,
    output logic [31:0]         mem_wr_data,
    input  logic [31:0]         mem_rd_data,

    output logic                busy,
    output logic                grant,
    output logic [1:0]          state_dbg
);

    localparam int CW = LINE_ADDR_LEN + 1;
    localparam logic [CW-1:0]            CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]            CNT_LAST = CW'(L - 1);
    localparam logic [CW-1:0]            CNT_END  = CW'(L);
    localparam logic [LINE_ADDR_LEN-1:0] WORD_ONE = LINE_ADDR_LEN'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // cnt walks 0..L-1 for writes and 0..L for reads; the extra read step
    // absorbs the one-cycle memory read latency.
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [CW-1:0]            cnt_inc;
    logic [LINE_ADDR_LEN-1:0] next_word;
    logic [LINE_ADDR_LEN-1:0] cap_word;

    logic                     last_q, last_d;
    logic                     grant_q, grant_d;

    logic [LW-1:0]            line_q;
    logic [32*L-1:0]          wdata_q;

    logic [ADDR_LEN-1:0]      mem_addr_q, mem_addr_d;
    logic                     mem_wr_req_q, mem_wr_req_d;
    logic [31:0]              mem_wr_data_q, mem_wr_data_d;

    logic [32*L-1:0]          rq0_rdata_q, rq1_rdata_q;

    logic                     req_any;
    logic                     sel_idx;
    logic                     sel_we;
    logic [LW-1:0]            sel_addr;
    logic [32*L-1:0]          sel_wdata;
    logic                     take;
    logic                     capture;

    assign cnt_inc   = cnt_q + CNT_ONE;
    assign next_word = cnt_inc[LINE_ADDR_LEN-1:0];
    // The word finishing its read latency is the one addressed a cycle ago.
    assign cap_word  = cnt_q[LINE_ADDR_LEN-1:0] - WORD_ONE;
    assign capture   = (state_q == READ) && (cnt_q != '0);

    // Round-robin pick: a lone request wins outright, a tie goes to the
    // requester that was not served last.
    always_comb begin
        req_any = rq0_req | rq1_req;
        if (rq0_req && rq1_req) begin
            sel_idx = ~last_q;
        end else begin
            sel_idx = rq1_req;
        end
        sel_we    = sel_idx ? rq1_we    : rq0_we;
        sel_addr  = sel_idx ? rq1_addr  : rq0_addr;
        sel_wdata = sel_idx ? rq1_wdata : rq0_wdata;
    end

    // Next-state logic; memory-side outputs are precomputed so that the
    // registered values line up with the state/cnt of the same cycle.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_d        = last_q;
        grant_d       = grant_q;
        mem_addr_d    = mem_addr_q;
        mem_wr_req_d  = 1'b0;
        mem_wr_data_d = mem_wr_data_q;
        take          = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_any) begin
                    take       = 1'b1;
                    grant_d    = sel_idx;
                    last_d     = sel_idx;
                    cnt_d      = '0;
                    mem_addr_d = {sel_addr, {LINE_ADDR_LEN{1'b0}}};
                    if (sel_we) begin
                        state_d       = WRITE;
                        mem_wr_req_d  = 1'b1;
                        mem_wr_data_d = sel_wdata[31:0];
                    end else begin
                        state_d = READ;
                    end
                end
            end
            WRITE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d         = cnt_inc;
                    mem_addr_d    = {line_q, next_word};
                    mem_wr_req_d  = 1'b1;
                    mem_wr_data_d = wdata_q[32*int'(next_word) +: 32];
                end
            end
            READ: begin
                if (cnt_q == CNT_END) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_inc;
                    // Past the last word the address simply holds.
                    if (cnt_q < CNT_LAST) begin
                        mem_addr_d = {line_q, next_word};
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and memory-port registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            last_q        <= 1'b1;
            grant_q       <= 1'b0;
            mem_addr_q    <= '0;
            mem_wr_req_q  <= 1'b0;
            mem_wr_data_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_q        <= last_d;
            grant_q       <= grant_d;
            mem_addr_q    <= mem_addr_d;
            mem_wr_req_q  <= mem_wr_req_d;
            mem_wr_data_q <= mem_wr_data_d;
        end
    end

    // Latch the granted requester's line address and write data at grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_q  <= '0;
            wdata_q <= '0;
        end else if (take) begin
            line_q  <= sel_addr;
            wdata_q <= sel_wdata;
        end
    end

    // Read-line buffers: only the granted requester's buffer changes, one
    // word per cycle as read data arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rq0_rdata_q <= '0;
            rq1_rdata_q <= '0;
        end else if (capture) begin
            if (grant_q) begin
                rq1_rdata_q[32*int'(cap_word) +: 32] <= mem_rd_data;
            end else begin
                rq0_rdata_q[32*int'(cap_word) +: 32] <= mem_rd_data;
            end
        end
    end

    assign rq0_rdata   = rq0_rdata_q;
    assign rq1_rdata   = rq1_rdata_q;
    assign rq0_done    = (state_q == DONE) && !grant_q;
    assign rq1_done    = (state_q == DONE) && grant_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wr_req  = mem_wr_req_q;
    assign mem_wr_data = mem_wr_data_q;
    assign busy        = (state_q != IDLE);
    assign grant       = grant_q;
    assign state_dbg   = state_q;

endmodule
